// File: rtl/b_resp_router_pkg.sv
//------------------------------------------------------------------------------
// b_resp_router_pkg
//   Shared AXI widths, response encodings, routing targets and the address
//   map used by the B-response router and its tag FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package b_resp_router_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        TGT_S0  = 2'd0,
        TGT_S1  = 2'd1,
        TGT_DEF = 2'd2
    } tgt_e;

    localparam logic [AXI_ADDR_BITS-1:0] S0_BASE = 32'h0000_0000;
    localparam logic [AXI_ADDR_BITS-1:0] S0_LAST = 32'h0000_FFFF;
    localparam logic [AXI_ADDR_BITS-1:0] S1_BASE = 32'h0001_0000;
    localparam logic [AXI_ADDR_BITS-1:0] S1_LAST = 32'h0001_FFFF;

    // S0 starts at address zero, so only its upper bound needs comparing.
    function automatic tgt_e decode_target(input logic [AXI_ADDR_BITS-1:0] addr);
        tgt_e tgt;
        if (addr <= S0_LAST) begin
            tgt = TGT_S0;
        end else if ((addr >= S1_BASE) && (addr <= S1_LAST)) begin
            tgt = TGT_S1;
        end else begin
            tgt = TGT_DEF;
        end
        return tgt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/b_resp_router_if.sv
//------------------------------------------------------------------------------
// b_resp_router_if
//   Bundles the observed master AW/W channels, the two slave B channels, the
//   master B channel and the router status outputs.
//   modport slave  : the router's view (observes AW/W, owns B routing)
//   modport master : the surrounding interconnect / environment view
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface b_resp_router_if;
    import b_resp_router_pkg::*;

    // observed master AW channel
    logic [AXI_ID_BITS-1:0]   AWID_M;
    logic [AXI_ADDR_BITS-1:0] AWADDR_M;
    logic                     AWVALID_M;
    logic                     AWREADY_M;
    // observed master W channel
    logic                     WVALID_M;
    logic                     WREADY_M;
    logic                     WLAST_M;
    // tracker / W routing status
    logic                     TRK_FULL;
    logic [1:0]               W_SEL;
    logic                     W_SEL_VLD;
    logic                     WREADY_DEF;
    // slave B channels
    logic [AXI_IDS_BITS-1:0]  BID_S0;
    logic [1:0]               BRESP_S0;
    logic                     BVALID_S0;
    logic                     BREADY_S0;
    logic [AXI_IDS_BITS-1:0]  BID_S1;
    logic [1:0]               BRESP_S1;
    logic                     BVALID_S1;
    logic                     BREADY_S1;
    // master B channel
    logic [AXI_ID_BITS-1:0]   BID_M;
    logic [1:0]               BRESP_M;
    logic                     BVALID_M;
    logic                     BREADY_M;
    // sticky slave ID mismatch
    logic                     ID_ERR;

    modport slave (
        input  AWID_M, AWADDR_M, AWVALID_M, AWREADY_M,
        input  WVALID_M, WREADY_M, WLAST_M,
        output TRK_FULL, W_SEL, W_SEL_VLD, WREADY_DEF,
        input  BID_S0, BRESP_S0, BVALID_S0,
        output BREADY_S0,
        input  BID_S1, BRESP_S1, BVALID_S1,
        output BREADY_S1,
        output BID_M, BRESP_M, BVALID_M,
        input  BREADY_M,
        output ID_ERR
    );

    modport master (
        output AWID_M, AWADDR_M, AWVALID_M, AWREADY_M,
        output WVALID_M, WREADY_M, WLAST_M,
        input  TRK_FULL, W_SEL, W_SEL_VLD, WREADY_DEF,
        output BID_S0, BRESP_S0, BVALID_S0,
        input  BREADY_S0,
        output BID_S1, BRESP_S1, BVALID_S1,
        input  BREADY_S1,
        input  BID_M, BRESP_M, BVALID_M,
        output BREADY_M,
        input  ID_ERR
    );

endinterface

`default_nettype wire

// File: rtl/b_resp_router_tag_fifo.sv
//------------------------------------------------------------------------------
// b_tag_fifo
//   Outstanding-write tracker. Each entry holds {target, AWID}. Three
//   pointers walk the same storage: wr (next free slot), w (oldest write
//   still waiting for WLAST) and rd (oldest write waiting for its B
//   response). rd <= w <= wr always holds.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     i_push/_tgt/_id       AW handshake: write a new entry (ignored if full)
//     i_w_adv               WLAST handshake: retire the entry at w
//     i_pop                 B handshake: retire the entry at rd
//     o_full, o_empty       occupancy DEPTH / zero
//     o_w_vld, o_w_tgt      an entry awaits WLAST, and its target
//     o_head_tgt/_id        entry at rd
//     o_head_w_done         the head entry has already seen its WLAST
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module b_tag_fifo
    import b_resp_router_pkg::*;
#(
    parameter int DEPTH = 4   // power of two, >= 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_push,
    input  wire tgt_e                   i_push_tgt,
    input  wire logic [AXI_ID_BITS-1:0] i_push_id,
    input  wire logic                   i_w_adv,
    input  wire logic                   i_pop,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_w_vld,
    output tgt_e                        o_w_tgt,
    output tgt_e                        o_head_tgt,
    output logic [AXI_ID_BITS-1:0]      o_head_id,
    output logic                        o_head_w_done
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(DEPTH);

    // The extra MSB on each pointer distinguishes full from empty.
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_w_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    tgt_e                   r_tgt_mem [DEPTH];
    logic [AXI_ID_BITS-1:0] r_id_mem  [DEPTH];

    logic [c_PTR_W-1:0]     w_occ;
    logic                   w_push_ok;
    logic                   w_w_adv_ok;
    logic                   w_pop_ok;

    assign w_occ         = r_wr_ptr - r_rd_ptr;
    assign o_full        = (w_occ == c_DEPTH);
    assign o_empty       = (r_rd_ptr == r_wr_ptr);
    assign o_w_vld       = (r_w_ptr != r_wr_ptr);
    assign o_head_w_done = (r_rd_ptr != r_w_ptr);

    // Full is evaluated on the registered pointers, so a push in the cycle
    // after a pop from full is accepted.
    assign w_push_ok  = i_push && !o_full;
    assign w_w_adv_ok = i_w_adv && o_w_vld;
    assign w_pop_ok   = i_pop && !o_empty;

    assign o_w_tgt    = r_tgt_mem[r_w_ptr[c_IDX_W-1:0]];
    assign o_head_tgt = r_tgt_mem[r_rd_ptr[c_IDX_W-1:0]];
    assign o_head_id  = r_id_mem[r_rd_ptr[c_IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_w_ptr  <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_w_adv_ok) begin
                r_w_ptr <= r_w_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage content is only ever observed through valid pointers, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_tgt_mem[r_wr_ptr[c_IDX_W-1:0]] <= i_push_tgt;
            r_id_mem[r_wr_ptr[c_IDX_W-1:0]]  <= i_push_id;
        end
    end

endmodule

`default_nettype wire

// File: rtl/b_resp_router.sv
//------------------------------------------------------------------------------
// b_resp_router
//   Tracks outstanding AXI writes by observing the master AW/W channels,
//   steers W to the default slave, and returns B responses to the master in
//   AW order. S0/S1 responses pass through combinationally; writes to
//   unmapped addresses are answered locally with DECERR once their WLAST
//   has been seen.
//   Ports:
//     ACLK, ARESETn   clock, asynchronous active-low reset
//     bus (slave)     AW/W observation, W routing status, slave and master
//                     B channels, sticky ID_ERR
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module b_resp_router
    import b_resp_router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic     ACLK,
    input  wire logic     ARESETn,
    b_resp_router_if.slave bus
);

    logic                   w_aw_hs;
    logic                   w_wlast_hs;
    logic                   w_b_hs;
    tgt_e                   w_aw_tgt;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_w_vld;
    tgt_e                   w_w_tgt;
    tgt_e                   w_head_tgt;
    logic [AXI_ID_BITS-1:0] w_head_id;
    logic                   w_head_w_done;
    logic                   w_s0_hs;
    logic                   w_s1_hs;
    logic                   w_id_mismatch;
    logic                   r_id_err;
    logic                   w_unused;

    assign w_aw_hs    = bus.AWVALID_M && bus.AWREADY_M;
    assign w_wlast_hs = bus.WVALID_M && bus.WREADY_M && bus.WLAST_M;
    assign w_aw_tgt   = decode_target(bus.AWADDR_M);

    b_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk           (ACLK),
        .rst_n         (ARESETn),
        .i_push        (w_aw_hs),
        .i_push_tgt    (w_aw_tgt),
        .i_push_id     (bus.AWID_M),
        .i_w_adv       (w_wlast_hs),
        .i_pop         (w_b_hs),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_w_vld       (w_w_vld),
        .o_w_tgt       (w_w_tgt),
        .o_head_tgt    (w_head_tgt),
        .o_head_id     (w_head_id),
        .o_head_w_done (w_head_w_done)
    );

    // W routing status; W_SEL is forced to 0 when nothing is pending so the
    // unreset storage never leaks out.
    assign bus.TRK_FULL   = w_full;
    assign bus.W_SEL_VLD  = w_w_vld;
    assign bus.W_SEL      = w_w_vld ? w_w_tgt : TGT_S0;
    assign bus.WREADY_DEF = w_w_vld && (w_w_tgt == TGT_DEF);

    // B routing follows the head entry only; a non-head slave sees
    // BREADY=0 and so cannot complete a handshake.
    always_comb begin
        bus.BVALID_M  = 1'b0;
        bus.BRESP_M   = RESP_OKAY;
        bus.BID_M     = '0;
        bus.BREADY_S0 = 1'b0;
        bus.BREADY_S1 = 1'b0;
        if (!w_empty) begin
            case (w_head_tgt)
                TGT_S0: begin
                    bus.BVALID_M  = bus.BVALID_S0;
                    bus.BRESP_M   = bus.BRESP_S0;
                    bus.BID_M     = bus.BID_S0[AXI_ID_BITS-1:0];
                    bus.BREADY_S0 = bus.BREADY_M;
                end
                TGT_S1: begin
                    bus.BVALID_M  = bus.BVALID_S1;
                    bus.BRESP_M   = bus.BRESP_S1;
                    bus.BID_M     = bus.BID_S1[AXI_ID_BITS-1:0];
                    bus.BREADY_S1 = bus.BREADY_M;
                end
                default: begin
                    // Local DECERR, held off until the write data is done.
                    bus.BVALID_M  = w_head_w_done;
                    bus.BRESP_M   = RESP_DECERR;
                    bus.BID_M     = w_head_id;
                end
            endcase
        end
    end

    assign w_b_hs  = bus.BVALID_M && bus.BREADY_M;
    assign w_s0_hs = bus.BVALID_S0 && bus.BREADY_S0;
    assign w_s1_hs = bus.BVALID_S1 && bus.BREADY_S1;

    assign w_id_mismatch =
        (w_s0_hs && (bus.BID_S0[AXI_ID_BITS-1:0] != w_head_id)) ||
        (w_s1_hs && (bus.BID_S1[AXI_ID_BITS-1:0] != w_head_id));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_id_err <= 1'b0;
        end else if (w_id_mismatch) begin
            r_id_err <= 1'b1;
        end
    end

    assign bus.ID_ERR = r_id_err;

    // Upper slave ID bits carry the interconnect's port tag and are not used.
    assign w_unused = ^{bus.BID_S0[AXI_IDS_BITS-1:AXI_ID_BITS],
                        bus.BID_S1[AXI_IDS_BITS-1:AXI_ID_BITS]};

endmodule

`default_nettype wire

// File: tb/tb_b_resp_router.sv
//------------------------------------------------------------------------------
// tb_b_resp_router
//   Directed self-checking bench for b_resp_router (DEPTH = 4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_b_resp_router;

    logic ACLK;
    logic ARESETn;
    int   n_tests;
    int   n_fail;

    b_resp_router_if bus ();

    b_resp_router #(.DEPTH(4)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // AW handshake spanning one rising edge; returns #1 after the next
    // falling edge so the new entry is already visible.
    task automatic aw(input logic [31:0] addr, input logic [3:0] id);
        @(negedge ACLK);
        bus.AWADDR_M  = addr;
        bus.AWID_M    = id;
        bus.AWVALID_M = 1'b1;
        bus.AWREADY_M = 1'b1;
        @(negedge ACLK);
        bus.AWVALID_M = 1'b0;
        bus.AWREADY_M = 1'b0;
        #1;
    endtask

    task automatic wlast();
        @(negedge ACLK);
        bus.WVALID_M = 1'b1;
        bus.WREADY_M = 1'b1;
        bus.WLAST_M  = 1'b1;
        @(negedge ACLK);
        bus.WVALID_M = 1'b0;
        bus.WREADY_M = 1'b0;
        bus.WLAST_M  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        bus.BREADY_M = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        n_tests++; if (bus.TRK_FULL !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", bus.TRK_FULL); end
        n_tests++; if (bus.W_SEL_VLD !== 1'b0) begin n_fail++; $display("FAIL rst_wsel_vld got %b exp 0", bus.W_SEL_VLD); end
        n_tests++; if (bus.W_SEL !== 2'd0) begin n_fail++; $display("FAIL rst_wsel got %0d exp 0", bus.W_SEL); end
        n_tests++; if (bus.WREADY_DEF !== 1'b0) begin n_fail++; $display("FAIL rst_wready_def got %b exp 0", bus.WREADY_DEF); end
        n_tests++; if (bus.BVALID_M !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got %b exp 0", bus.BVALID_M); end
        n_tests++; if ({bus.BREADY_S0, bus.BREADY_S1} !== 2'b00) begin n_fail++; $display("FAIL rst_bready_s got %b exp 00", {bus.BREADY_S0, bus.BREADY_S1}); end
        n_tests++; if ({bus.BID_M, bus.BRESP_M} !== 6'd0) begin n_fail++; $display("FAIL rst_bid_bresp got %h exp 0", {bus.BID_M, bus.BRESP_M}); end
        n_tests++; if (bus.ID_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_id_err got %b exp 0", bus.ID_ERR); end
        @(negedge ACLK);
        ARESETn = 1'b1;
        bus.BREADY_M = 1'b0;
    endtask

    task automatic test_s0_basic();
        bus.BREADY_M = 1'b1;
        aw(32'h0000_0010, 4'd3);
        n_tests++; if ({bus.W_SEL_VLD, bus.W_SEL, bus.WREADY_DEF} !== 4'b1_00_0) begin n_fail++; $display("FAIL s0_wsel got %b exp 1000", {bus.W_SEL_VLD, bus.W_SEL, bus.WREADY_DEF}); end
        n_tests++; if (bus.BVALID_M !== 1'b0) begin n_fail++; $display("FAIL s0_bvalid_idle got %b exp 0", bus.BVALID_M); end
        wlast();
        n_tests++; if (bus.W_SEL_VLD !== 1'b0) begin n_fail++; $display("FAIL s0_wsel_done got %b exp 0", bus.W_SEL_VLD); end
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b1; bus.BID_S0 = 8'h13; bus.BRESP_S0 = 2'd0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BID_M, bus.BRESP_M} !== {1'b1, 4'd3, 2'd0}) begin n_fail++; $display("FAIL s0_bresp got v%b id%0h r%0d exp v1 id3 r0", bus.BVALID_M, bus.BID_M, bus.BRESP_M); end
        n_tests++; if ({bus.BREADY_S0, bus.BREADY_S1} !== 2'b10) begin n_fail++; $display("FAIL s0_bready got %b exp 10", {bus.BREADY_S0, bus.BREADY_S1}); end
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b0;
        #1;
        n_tests++; if (bus.BREADY_S0 !== 1'b0) begin n_fail++; $display("FAIL s0_empty_bready got %b exp 0", bus.BREADY_S0); end
        n_tests++; if (bus.ID_ERR !== 1'b0) begin n_fail++; $display("FAIL s0_id_err got %b exp 0", bus.ID_ERR); end
    endtask

    task automatic test_def();
        bus.BREADY_M = 1'b1;
        aw(32'h0002_0000, 4'd5);
        n_tests++; if ({bus.WREADY_DEF, bus.W_SEL} !== 3'b1_10) begin n_fail++; $display("FAIL def_wready got %b exp 110", {bus.WREADY_DEF, bus.W_SEL}); end
        n_tests++; if (bus.BVALID_M !== 1'b0) begin n_fail++; $display("FAIL def_early_bvalid got %b exp 0", bus.BVALID_M); end
        @(negedge ACLK);
        bus.WVALID_M = 1'b1; bus.WREADY_M = 1'b1; bus.WLAST_M = 1'b1;
        #1;
        n_tests++; if (bus.BVALID_M !== 1'b0) begin n_fail++; $display("FAIL def_same_cycle_bvalid got %b exp 0", bus.BVALID_M); end
        @(negedge ACLK);
        bus.WVALID_M = 1'b0; bus.WREADY_M = 1'b0; bus.WLAST_M = 1'b0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BRESP_M, bus.BID_M} !== {1'b1, 2'd3, 4'd5}) begin n_fail++; $display("FAIL def_bresp got v%b r%0d id%0h exp v1 r3 id5", bus.BVALID_M, bus.BRESP_M, bus.BID_M); end
        n_tests++; if ({bus.BREADY_S0, bus.BREADY_S1} !== 2'b00) begin n_fail++; $display("FAIL def_bready_s got %b exp 00", {bus.BREADY_S0, bus.BREADY_S1}); end
        @(negedge ACLK);
        #1;
        n_tests++; if (bus.BVALID_M !== 1'b0) begin n_fail++; $display("FAIL def_popped got %b exp 0", bus.BVALID_M); end
    endtask

    task automatic test_full();
        logic [1:0] exp_tgt [4];
        exp_tgt[0] = 2'd0; exp_tgt[1] = 2'd1; exp_tgt[2] = 2'd2; exp_tgt[3] = 2'd0;
        bus.BREADY_M = 1'b0;
        aw(32'h0000_0100, 4'd1);
        aw(32'h0001_0000, 4'd2);
        n_tests++; if (bus.TRK_FULL !== 1'b0) begin n_fail++; $display("FAIL full_early got %b exp 0", bus.TRK_FULL); end
        aw(32'h0003_0000, 4'd4);
        aw(32'h0000_FFFF, 4'd6);
        n_tests++; if (bus.TRK_FULL !== 1'b1) begin n_fail++; $display("FAIL full_set got %b exp 1", bus.TRK_FULL); end
        aw(32'h0000_0010, 4'd7);
        n_tests++; if (bus.TRK_FULL !== 1'b1) begin n_fail++; $display("FAIL full_hold got %b exp 1", bus.TRK_FULL); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if ({bus.W_SEL_VLD, bus.W_SEL} !== {1'b1, exp_tgt[i]}) begin n_fail++; $display("FAIL full_wsel%0d got %b exp 1%b", i, {bus.W_SEL_VLD, bus.W_SEL}, exp_tgt[i]); end
            wlast();
        end
        n_tests++; if (bus.W_SEL_VLD !== 1'b0) begin n_fail++; $display("FAIL full_fifth_ignored got %b exp 0", bus.W_SEL_VLD); end
        bus.BREADY_M = 1'b1;
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b1; bus.BID_S0 = 8'h01; bus.BRESP_S0 = 2'd0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BID_M, bus.BREADY_S0} !== {1'b1, 4'd1, 1'b1}) begin n_fail++; $display("FAIL full_rsp0 got v%b id%0h rdy%b exp v1 id1 rdy1", bus.BVALID_M, bus.BID_M, bus.BREADY_S0); end
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b0;
        bus.BVALID_S1 = 1'b1; bus.BID_S1 = 8'h22; bus.BRESP_S1 = 2'd0;
        #1;
        n_tests++; if (bus.TRK_FULL !== 1'b0) begin n_fail++; $display("FAIL full_clear got %b exp 0", bus.TRK_FULL); end
        n_tests++; if ({bus.BVALID_M, bus.BID_M, bus.BREADY_S0, bus.BREADY_S1} !== {1'b1, 4'd2, 2'b01}) begin n_fail++; $display("FAIL full_rsp1 got v%b id%0h rdy%b%b exp v1 id2 rdy01", bus.BVALID_M, bus.BID_M, bus.BREADY_S0, bus.BREADY_S1); end
        @(negedge ACLK);
        bus.BVALID_S1 = 1'b0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BRESP_M, bus.BID_M} !== {1'b1, 2'd3, 4'd4}) begin n_fail++; $display("FAIL full_rsp2 got v%b r%0d id%0h exp v1 r3 id4", bus.BVALID_M, bus.BRESP_M, bus.BID_M); end
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b1; bus.BID_S0 = 8'h06; bus.BRESP_S0 = 2'd0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BID_M, bus.BREADY_S0} !== {1'b1, 4'd6, 1'b1}) begin n_fail++; $display("FAIL full_rsp3 got v%b id%0h rdy%b exp v1 id6 rdy1", bus.BVALID_M, bus.BID_M, bus.BREADY_S0); end
        @(negedge ACLK);
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BREADY_S0} !== 2'b00) begin n_fail++; $display("FAIL full_drained got %b exp 00", {bus.BVALID_M, bus.BREADY_S0}); end
        bus.BVALID_S0 = 1'b0;
    endtask

    task automatic test_out_of_order();
        bus.BREADY_M = 1'b1;
        aw(32'h0000_0200, 4'd8);
        aw(32'h0001_8000, 4'd9);
        wlast();
        wlast();
        @(negedge ACLK);
        bus.BVALID_S1 = 1'b1; bus.BID_S1 = 8'h09; bus.BRESP_S1 = 2'd0;
        #1;
        n_tests++; if ({bus.BREADY_S1, bus.BVALID_M} !== 2'b00) begin n_fail++; $display("FAIL ooo_blocked got %b exp 00", {bus.BREADY_S1, bus.BVALID_M}); end
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b1; bus.BID_S0 = 8'h08; bus.BRESP_S0 = 2'd0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BID_M, bus.BREADY_S1} !== {1'b1, 4'd8, 1'b0}) begin n_fail++; $display("FAIL ooo_head got v%b id%0h rdy1 %b exp v1 id8 rdy1 0", bus.BVALID_M, bus.BID_M, bus.BREADY_S1); end
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BID_M, bus.BREADY_S1} !== {1'b1, 4'd9, 1'b1}) begin n_fail++; $display("FAIL ooo_second got v%b id%0h rdy1 %b exp v1 id9 rdy1 1", bus.BVALID_M, bus.BID_M, bus.BREADY_S1); end
        @(negedge ACLK);
        bus.BVALID_S1 = 1'b0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.W_SEL_VLD, bus.ID_ERR} !== 3'b000) begin n_fail++; $display("FAIL ooo_empty got %b exp 000", {bus.BVALID_M, bus.W_SEL_VLD, bus.ID_ERR}); end
    endtask

    task automatic test_id_err();
        bus.BREADY_M = 1'b1;
        aw(32'h0000_0040, 4'd3);
        wlast();
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b1; bus.BID_S0 = 8'h17; bus.BRESP_S0 = 2'd0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BID_M} !== {1'b1, 4'd7}) begin n_fail++; $display("FAIL iderr_fwd got v%b id%0h exp v1 id7", bus.BVALID_M, bus.BID_M); end
        n_tests++; if (bus.ID_ERR !== 1'b0) begin n_fail++; $display("FAIL iderr_not_yet got %b exp 0", bus.ID_ERR); end
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b0;
        #1;
        n_tests++; if (bus.ID_ERR !== 1'b1) begin n_fail++; $display("FAIL iderr_set got %b exp 1", bus.ID_ERR); end
        aw(32'h0001_0004, 4'd2);
        wlast();
        @(negedge ACLK);
        bus.BVALID_S1 = 1'b1; bus.BID_S1 = 8'h02; bus.BRESP_S1 = 2'd0;
        @(negedge ACLK);
        bus.BVALID_S1 = 1'b0;
        #1;
        n_tests++; if (bus.ID_ERR !== 1'b1) begin n_fail++; $display("FAIL iderr_sticky got %b exp 1", bus.ID_ERR); end
    endtask

    task automatic test_back_to_back();
        bus.BREADY_M = 1'b1;
        aw(32'h0000_0300, 4'd10);
        wlast();
        // Pop S0 head and push an S1 entry on the same edge.
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b1; bus.BID_S0 = 8'h0A; bus.BRESP_S0 = 2'd0;
        bus.AWADDR_M = 32'h0001_0100; bus.AWID_M = 4'd11;
        bus.AWVALID_M = 1'b1; bus.AWREADY_M = 1'b1;
        @(negedge ACLK);
        bus.BVALID_S0 = 1'b0;
        bus.AWVALID_M = 1'b0; bus.AWREADY_M = 1'b0;
        #1;
        n_tests++; if ({bus.W_SEL_VLD, bus.W_SEL, bus.BREADY_S1, bus.BREADY_S0} !== 5'b1_01_1_0) begin n_fail++; $display("FAIL b2b_state got %b exp 101 10", {bus.W_SEL_VLD, bus.W_SEL, bus.BREADY_S1, bus.BREADY_S0}); end
        wlast();
        @(negedge ACLK);
        bus.BVALID_S1 = 1'b1; bus.BID_S1 = 8'h0B; bus.BRESP_S1 = 2'd0;
        #1;
        n_tests++; if ({bus.BVALID_M, bus.BID_M} !== {1'b1, 4'd11}) begin n_fail++; $display("FAIL b2b_rsp got v%b id%0h exp v1 idb", bus.BVALID_M, bus.BID_M); end
        @(negedge ACLK);
        bus.BVALID_S1 = 1'b0;
        #1;
        n_tests++; if (bus.BREADY_S1 !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b exp 0", bus.BREADY_S1); end
    endtask

    task automatic test_reset_mid();
        bus.BREADY_M = 1'b1;
        aw(32'h0000_0500, 4'd1);
        aw(32'h0004_0000, 4'd2);
        n_tests++; if ({bus.W_SEL_VLD, bus.BREADY_S0} !== 2'b11) begin n_fail++; $display("FAIL rstmid_pending got %b exp 11", {bus.W_SEL_VLD, bus.BREADY_S0}); end
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        n_tests++; if ({bus.W_SEL_VLD, bus.W_SEL, bus.TRK_FULL, bus.WREADY_DEF} !== 5'b0) begin n_fail++; $display("FAIL rstmid_w got %b exp 00000", {bus.W_SEL_VLD, bus.W_SEL, bus.TRK_FULL, bus.WREADY_DEF}); end
        n_tests++; if ({bus.BVALID_M, bus.BREADY_S0, bus.BREADY_S1, bus.ID_ERR, bus.BID_M, bus.BRESP_M} !== 10'd0) begin n_fail++; $display("FAIL rstmid_b got %b exp 0", {bus.BVALID_M, bus.BREADY_S0, bus.BREADY_S1, bus.ID_ERR, bus.BID_M, bus.BRESP_M}); end
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        n_tests++; if ({bus.W_SEL_VLD, bus.BVALID_M, bus.BREADY_S0, bus.BREADY_S1} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_after got %b exp 0000", {bus.W_SEL_VLD, bus.BVALID_M, bus.BREADY_S0, bus.BREADY_S1}); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ARESETn = 1'b0;
        bus.AWID_M = '0; bus.AWADDR_M = '0; bus.AWVALID_M = 1'b0; bus.AWREADY_M = 1'b0;
        bus.WVALID_M = 1'b0; bus.WREADY_M = 1'b0; bus.WLAST_M = 1'b0;
        bus.BID_S0 = '0; bus.BRESP_S0 = '0; bus.BVALID_S0 = 1'b0;
        bus.BID_S1 = '0; bus.BRESP_S1 = '0; bus.BVALID_S1 = 1'b0;
        bus.BREADY_M = 1'b0;

        test_reset();
        test_s0_basic();
        test_def();
        test_full();
        test_out_of_order();
        test_back_to_back();
        test_id_err();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/b_resp_router.md
B_RESP_ROUTER -- requirements
Module: b_resp_router

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the outstanding-write tracker depth; it must be a power of 2 and at least 2.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 ACLK  input  1  clock; all state changes on its rising edge.
REQ-004 ARESETn  input  1  asynchronous active-low reset.
REQ-005 AWID_M, AWADDR_M, AWVALID_M, AWREADY_M  input  4/32/1/1  observed master AW channel; a handshake is AWVALID_M&&AWREADY_M.
REQ-006 WVALID_M, WREADY_M, WLAST_M  input  1 each  observed master W channel.
REQ-007 TRK_FULL  output  1  tracker full; the interconnect gates AWREADY_M with it.
REQ-008 W_SEL, W_SEL_VLD  output  2/1  W-route target of the oldest write still awaiting WLAST (0=S0, 1=S1, 2=DEF).
REQ-009 WREADY_DEF  output  1  default-slave W acceptance.
REQ-010 BID_S0/BID_S1, BRESP_S0/BRESP_S1, BVALID_S0/BVALID_S1  input  8/2/1 per slave  slave B channels.
REQ-011 BREADY_S0, BREADY_S1  output  1 each  slave B ready.
REQ-012 BID_M, BRESP_M, BVALID_M  output  4/2/1  master B channel; BREADY_M  input  1.
REQ-013 ID_ERR  output  1  sticky flag for a slave BID[3:0] mismatch.

Function
REQ-014 The block SHALL decode AWADDR_M as follows: 0x0000_0000..0x0000_FFFF -> S0; 0x0001_0000..0x0001_FFFF -> S1; any other address -> DEF.
REQ-015 On each AW handshake, the block SHALL push {target, AWID_M} into a tracker FIFO at wr_ptr.
REQ-016 The FIFO SHALL keep three pointers (wr, w, rd), each log2(DEPTH)+1 bits wide and wrapping modulo 2*DEPTH; the invariant is rd <= w <= wr.
REQ-017 TRK_FULL SHALL equal (wr-rd == DEPTH); an AW handshake while full SHALL be ignored.
REQ-018 W_SEL_VLD SHALL equal (w != wr), and W_SEL SHALL equal the target at w; a new entry becomes visible one cycle after its AW handshake.
REQ-019 WREADY_DEF SHALL equal W_SEL_VLD && W_SEL==DEF.
REQ-020 The w pointer SHALL advance on WVALID_M&&WREADY_M&&WLAST_M while W_SEL_VLD=1, for every target.
REQ-021 The B route SHALL be the target of the head entry at rd, and the routing SHALL apply only when rd != wr.
REQ-022 When the head target is S0 or S1: BVALID_M, BRESP_M and BID_M=BID_Sx[3:0] SHALL pass combinationally from the selected slave, and BREADY_Sx SHALL equal BREADY_M.
REQ-023 When the head target is DEF: BVALID_M SHALL equal (rd != w), BRESP_M SHALL be 2'b11 (DECERR), and BID_M SHALL be the stored ID.
REQ-024 A DEF response SHALL therefore appear no earlier than one cycle after its WLAST handshake.
REQ-025 The unselected BREADY_Sx SHALL be 0, and both BREADY_Sx SHALL be 0 when the tracker is empty.
REQ-026 rd SHALL advance on BVALID_M&&BREADY_M.
REQ-027 A push and a pop in the same cycle SHALL leave the occupancy unchanged, and a push SHALL be accepted in the cycle full clears.
REQ-028 A slave B handshake with BID_Sx[3:0] != stored ID SHALL set ID_ERR; the response SHALL still be forwarded.
REQ-029 A B_Sx handshake on a non-head slave SHALL NOT be possible, because its BREADY is 0.

Reset
REQ-030 ARESETn low SHALL asynchronously clear wr, w, rd and ID_ERR.
REQ-031 While in reset, the outputs SHALL be: TRK_FULL=0, W_SEL_VLD=0, W_SEL=0, WREADY_DEF=0, BVALID_M=0, BREADY_S0=0, BREADY_S1=0, BID_M=0, BRESP_M=0.
REQ-032 Reset mid-burst SHALL discard all outstanding entries with no response generated.

Structure
REQ-033 The shared AXI package SHALL hold AXI_ID_BITS=4, AXI_IDS_BITS=8, AXI_ADDR_BITS=32, the RESP encodings (OKAY=0, DECERR=3), the target enum {TGT_S0, TGT_S1, TGT_DEF} and the address-map bounds.
REQ-034 One sub-module, b_tag_fifo, SHALL contain the storage, the three pointers and the full/valid logic; b_resp_router SHALL contain the decode and the muxing.

Verification
REQ-035 AW 0x0000_0010 ID=3; W single beat; S0 BVALID with BID=0x13, BRESP=0 -> BID_M=3, BRESP_M=0, BREADY_S0=1, BREADY_S1=0.
REQ-036 AW 0x0002_0000 ID=5; W beat WLAST -> WREADY_DEF=1; BVALID_M=1 one cycle later with BRESP_M=3 and BID_M=5; no slave BREADY asserted.
REQ-037 Four AWs (S0,S1,DEF,S0) with no B -> TRK_FULL=1 after the fourth; a fifth AW is ignored; responses return in order S0,S1,DEF,S0.
REQ-038 S1 responds first while the head is S0 -> BREADY_S1=0 and BVALID_M follows S0 only; when S0 completes, S1 is forwarded.
REQ-039 S0 returns BID=0x17 for stored ID 3 -> ID_ERR=1 and stays 1; the response is still forwarded.
REQ-040 ARESETn dropped with 2 entries pending -> all outputs reach their reset values immediately, and the tracker is empty after release.
